crc_stream_engine: RTL and testbench

- Parametrised, frame-oriented CRC engine; successor to the fixed 16-bit, 16-bit-word CRC16 block.
- Generic data width, CRC width, polynomial, init value and output XOR.
- Adds ready/valid handshakes on both sides, explicit frame delimiting, result hold under backpressure, an optional compare-against-expected check, abort, and a per-frame word counter.
- Sits between packet framers and link/DMA logic.

---
 rtl/crc_stream_engine.sv | 130 +++++++++++++
 tb/tb_crc_stream_engine.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_stream_engine.sv
`default_nettype none
// ============================================================================
// Module   : crc_stream_engine
// Purpose  : Parametrised frame-oriented CRC engine with ready/valid handshakes,
//            result hold, compare-against-expected, abort and word counter.
// Revision : 1.0 - initial release
// ============================================================================
module crc_stream_engine #(
  parameter int               DATA_W  = 16,
  parameter int               CRC_W   = 16,
  parameter logic [CRC_W-1:0] POLY    = 'h1021,
  parameter logic [CRC_W-1:0] INIT    = 'h0000,
  parameter logic [CRC_W-1:0] XOR_OUT = 'h0000,
  parameter int               LEN_W   = 16
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic [CRC_W-1:0]  in_chk,
  input  logic              abort,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CRC_W-1:0]  out_crc,
  output logic              out_match,
  output logic [LEN_W-1:0]  out_len
);

  localparam logic [1:0]       S_IDLE  = 2'd0;
  localparam logic [1:0]       S_BUSY  = 2'd1;
  localparam logic [1:0]       S_DONE  = 2'd2;
  localparam logic [LEN_W-1:0] LEN_MAX = '1;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [CRC_W-1:0] r_crc;
  logic [LEN_W-1:0] r_len;
  logic [CRC_W-1:0] r_out_crc;
  logic             r_out_match;
  logic [LEN_W-1:0] r_out_len;

  logic             w_acc;
  logic             w_hs;
  logic             w_abort;
  logic [CRC_W-1:0] w_crc_nxt;
  logic [CRC_W-1:0] w_crc_fin;
  logic [LEN_W-1:0] w_len_inc;
  logic [CRC_W-1:0] w_chain [DATA_W+1];

  // MSB-first Galois LFSR, one stage per data bit, fully unrolled
  assign w_chain[0] = r_crc;
  generate
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_lfsr
      logic w_fb;
      assign w_fb          = w_chain[gi][CRC_W-1] ^ in_data[DATA_W-1-gi];
      assign w_chain[gi+1] = {w_chain[gi][CRC_W-2:0], 1'b0} ^ (w_fb ? POLY : '0);
    end
  endgenerate

  assign w_crc_nxt = w_chain[DATA_W];
  assign w_crc_fin = w_crc_nxt ^ XOR_OUT;
  assign w_len_inc = (r_len == LEN_MAX) ? r_len : r_len + LEN_W'(1);
  // abort only matters while a frame can still be collected
  assign w_abort   = abort && (r_state != S_DONE);
  assign w_acc     = in_valid && in_ready && !abort;
  assign w_hs      = out_valid && out_ready;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_BUSY: begin
        if (w_abort) begin
          w_state_nxt = S_IDLE;
        end else if (w_acc) begin
          w_state_nxt = in_last ? S_DONE : S_BUSY;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == S_IDLE) || (r_state == S_BUSY);
    out_valid = (r_state == S_DONE);
    out_match = r_out_match && (r_state == S_DONE);
    out_crc   = r_out_crc;
    out_len   = r_out_len;
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_crc       <= INIT;
      r_len       <= '0;
      r_out_crc   <= '0;
      r_out_match <= 1'b0;
      r_out_len   <= '0;
    end else if (w_abort) begin
      r_crc <= INIT;
      r_len <= '0;
    end else if (w_acc) begin
      r_crc <= w_crc_nxt;
      r_len <= w_len_inc;
      if (in_last) begin
        r_out_crc   <= w_crc_fin;
        r_out_len   <= w_len_inc;
        r_out_match <= (w_crc_fin == in_chk);
      end
    end else if (w_hs) begin
      r_crc <= INIT;
      r_len <= '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_crc_stream_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_crc_stream_engine
// Purpose  : Randomised self-checking bench for four engine configurations
//            against a bit-stream CRC reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_crc_stream_engine;

  logic        clk;
  logic        rst_n;
  int          sel;
  logic        vld, rdy, abt, last;
  logic [63:0] din;
  logic [31:0] chk;

  logic        ir0, ir1, ir2, ir3;
  logic        ov0, ov1, ov2, ov3;
  logic        om0, om1, om2, om3;
  logic [15:0] c0, c1, c3;
  logic [31:0] c2;
  logic [15:0] l0, l1, l2;
  logic [2:0]  l3;

  logic        m_ir, m_ov, m_om;
  logic [31:0] m_crc;
  logic [15:0] m_len;

  int          n_vec;
  int          n_err;
  logic [63:0] frm[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 0: XMODEM bytes, 1: CCITT-FALSE bytes, 2: CRC-32 bytes, 3: XMODEM 16-bit words, 3-bit counter
  crc_stream_engine #(.DATA_W(8), .CRC_W(16), .POLY('h1021), .INIT('h0000), .XOR_OUT('h0000), .LEN_W(16)) u_x8 (
    .clk_in(clk), .rst_n(rst_n), .in_valid(vld && sel == 0), .in_ready(ir0), .in_data(din[7:0]),
    .in_last(last), .in_chk(chk[15:0]), .abort(abt && sel == 0), .out_valid(ov0),
    .out_ready(rdy && sel == 0), .out_crc(c0), .out_match(om0), .out_len(l0));

  crc_stream_engine #(.DATA_W(8), .CRC_W(16), .POLY('h1021), .INIT('hFFFF), .XOR_OUT('h0000), .LEN_W(16)) u_cf (
    .clk_in(clk), .rst_n(rst_n), .in_valid(vld && sel == 1), .in_ready(ir1), .in_data(din[7:0]),
    .in_last(last), .in_chk(chk[15:0]), .abort(abt && sel == 1), .out_valid(ov1),
    .out_ready(rdy && sel == 1), .out_crc(c1), .out_match(om1), .out_len(l1));

  crc_stream_engine #(.DATA_W(8), .CRC_W(32), .POLY('h04C11DB7), .INIT('hFFFFFFFF), .XOR_OUT('hFFFFFFFF), .LEN_W(16)) u_c32 (
    .clk_in(clk), .rst_n(rst_n), .in_valid(vld && sel == 2), .in_ready(ir2), .in_data(din[7:0]),
    .in_last(last), .in_chk(chk), .abort(abt && sel == 2), .out_valid(ov2),
    .out_ready(rdy && sel == 2), .out_crc(c2), .out_match(om2), .out_len(l2));

  crc_stream_engine #(.DATA_W(16), .CRC_W(16), .POLY('h1021), .INIT('h0000), .XOR_OUT('h0000), .LEN_W(3)) u_x16 (
    .clk_in(clk), .rst_n(rst_n), .in_valid(vld && sel == 3), .in_ready(ir3), .in_data(din[15:0]),
    .in_last(last), .in_chk(chk[15:0]), .abort(abt && sel == 3), .out_valid(ov3),
    .out_ready(rdy && sel == 3), .out_crc(c3), .out_match(om3), .out_len(l3));

  always_comb begin
    m_ir = ir0; m_ov = ov0; m_om = om0; m_crc = {16'h0, c0}; m_len = l0;
    case (sel)
      1: begin m_ir = ir1; m_ov = ov1; m_om = om1; m_crc = {16'h0, c1}; m_len = l1; end
      2: begin m_ir = ir2; m_ov = ov2; m_om = om2; m_crc = c2; m_len = l2; end
      3: begin m_ir = ir3; m_ov = ov3; m_om = om3; m_crc = {16'h0, c3}; m_len = {13'h0, l3}; end
      default: ;
    endcase
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int dw_of(input int k);
    return (k == 3) ? 16 : 8;
  endfunction

  function automatic logic [31:0] mask_of(input int k);
    return (k == 2) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
  endfunction

  function automatic int len_of(input int k, input int n);
    int lmax;
    lmax = (k == 3) ? 7 : 65535;
    return (n > lmax) ? lmax : n;
  endfunction

  // CRC of the frame as one serial bit stream, first word's MSB first
  function automatic logic [31:0] model_crc(input int k);
    int          cw, dw;
    logic [31:0] poly, init, xo, mask, crc;
    bit          bits[$];
    bit          top;
    cw = 16; dw = dw_of(k); poly = 32'h1021; init = 32'h0; xo = 32'h0;
    if (k == 1) init = 32'hFFFF;
    if (k == 2) begin cw = 32; poly = 32'h04C1_1DB7; init = '1; xo = '1; end
    mask = mask_of(k);
    foreach (frm[i]) for (int b = dw - 1; b >= 0; b--) bits.push_back(frm[i][b]);
    crc = init;
    foreach (bits[j]) begin
      top = crc[cw-1] ^ bits[j];
      crc = (crc << 1) & mask;
      if (top) crc = crc ^ poly;
    end
    return (crc ^ xo) & mask;
  endfunction

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  function automatic logic [31:0] rev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  // Sends frm to instance k, checks the held result, then consumes it
  task automatic send_frame(input int k, input logic [31:0] c, input int gmax,
                            input int hold, input bit abort_done);
    logic [31:0] ecrc;
    int          elen;
    bit          emat;
    ecrc = model_crc(k);
    elen = len_of(k, frm.size());
    emat = (ecrc == (c & mask_of(k)));
    sel  = k;
    for (int i = 0; i < frm.size(); i++) begin
      int g;
      g = (gmax > 0) ? $urandom_range(0, gmax) : 0;
      repeat (g) begin @(negedge clk); vld = 1'b0; end
      @(negedge clk);
      if (i == 0) check_eq("in_ready_idle", m_ir, 1);
      vld = 1'b1; din = frm[i]; last = (i == frm.size() - 1); chk = c;
    end
    @(negedge clk);
    vld = 1'b0; last = 1'b0;
    check_eq("out_valid_latency", m_ov, 1);
    check_eq("out_crc", m_crc, ecrc);
    check_eq("out_match", m_om, emat);
    check_eq("out_len", m_len, elen);
    check_eq("in_ready_done", m_ir, 0);
    for (int h = 0; h < hold; h++) begin
      vld = 1'b1; din = {$urandom, $urandom}; last = ($urandom_range(0, 1) == 1);
      abt = abort_done;
      @(negedge clk);
    end
    vld = 1'b0; last = 1'b0; abt = 1'b0;
    if (hold > 0) begin
      check_eq("hold_valid", m_ov, 1);
      check_eq("hold_crc", m_crc, ecrc);
      check_eq("hold_len", m_len, elen);
      check_eq("hold_match", m_om, emat);
      check_eq("hold_in_ready", m_ir, 0);
    end
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
    check_eq("post_hs_valid", m_ov, 0);
    check_eq("post_hs_in_ready", m_ir, 1);
    check_eq("post_hs_match", m_om, 0);
    check_eq("post_hs_crc_kept", m_crc, ecrc);
    check_eq("post_hs_len_kept", m_len, elen);
  endtask

  task automatic fill_random(input int k, input int n);
    logic [63:0] m;
    m = (dw_of(k) == 16) ? 64'hFFFF : 64'hFF;
    frm.delete();
    for (int i = 0; i < n; i++) frm.push_back({$urandom, $urandom} & m);
  endtask

  initial begin
    logic [31:0] cv;
    n_vec = 0; n_err = 0;
    sel = 0; vld = 0; rdy = 0; abt = 0; last = 0; din = '0; chk = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_in_ready", m_ir, 1);
    check_eq("rst_out_valid", m_ov, 0);
    check_eq("rst_out_crc", m_crc, 0);
    check_eq("rst_out_len", m_len, 0);
    check_eq("rst_out_match", m_om, 0);
    rst_n = 1'b1;
    @(negedge clk);

    frm.delete();
    for (int i = 0; i < 9; i++) frm.push_back(64'h31 + 64'(i));
    send_frame(0, 32'h31C3, 0, 0, 0);
    check_eq("xmodem_check_value", m_crc, 32'h31C3);
    send_frame(1, 32'h29B1, 0, 0, 0);
    check_eq("ccitt_false_check_value", m_crc, 32'h29B1);

    frm.delete();
    for (int i = 0; i < 9; i++) frm.push_back({56'h0, rev8(8'h31 + 8'(i))});
    send_frame(2, rev32(32'hCBF4_3926), 0, 0, 0);
    check_eq("crc32_check_value", m_crc, rev32(32'hCBF4_3926));

    frm.delete();
    for (int i = 0; i < 8; i++) frm.push_back(64'h31 + 64'(i));
    cv = model_crc(0);
    send_frame(0, cv, 0, 0, 0);
    frm.delete();
    frm.push_back(64'h3132); frm.push_back(64'h3334); frm.push_back(64'h3536); frm.push_back(64'h3738);
    send_frame(3, cv, 0, 0, 0);
    check_eq("width_equiv_crc", m_crc, cv);

    fill_random(1, 7);
    send_frame(1, model_crc(1), 3, 5, 0);
    fill_random(1, 3);
    send_frame(1, model_crc(1), 0, 0, 0);

    sel = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); vld = 1'b1; din = 64'($urandom_range(0, 255)); last = 1'b0;
    end
    @(negedge clk); vld = 1'b1; din = 64'hAA; abt = 1'b1;
    @(negedge clk); last = 1'b1; din = 64'h55;
    @(negedge clk); vld = 1'b0; abt = 1'b0; last = 1'b0;
    check_eq("abort_no_result", m_ov, 0);
    check_eq("abort_in_ready", m_ir, 1);
    fill_random(0, 5);
    send_frame(0, model_crc(0), 1, 0, 0);
    fill_random(0, 4);
    send_frame(0, model_crc(0), 0, 3, 1);

    for (int i = 0; i < 2; i++) begin
      @(negedge clk); vld = 1'b1; din = 64'($urandom_range(0, 255)); last = 1'b0;
    end
    @(negedge clk); vld = 1'b0; rst_n = 1'b0;
    #1;
    check_eq("rst_busy_valid", m_ov, 0);
    check_eq("rst_busy_crc", m_crc, 0);
    check_eq("rst_busy_len", m_len, 0);
    @(negedge clk); rst_n = 1'b1;
    frm.delete(); frm.push_back(64'h5A);
    send_frame(0, model_crc(0) ^ 32'h1, 0, 0, 0);
    check_eq("one_word_len", m_len, 1);

    @(negedge clk); vld = 1'b1; din = 64'h77; last = 1'b1;
    @(negedge clk); vld = 1'b0; last = 1'b0;
    check_eq("pre_rst_done_valid", m_ov, 1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_done_valid", m_ov, 0);
    check_eq("rst_done_len", m_len, 0);
    @(negedge clk); rst_n = 1'b1;

    fill_random(3, 10);
    send_frame(3, model_crc(3), 0, 0, 0);

    for (int f = 0; f < 16; f++) begin
      int k;
      k = $urandom_range(0, 3);
      fill_random(k, $urandom_range(1, 12));
      cv = ($urandom_range(0, 1) == 1) ? model_crc(k) : $urandom;
      send_frame(k, cv, 2, $urandom_range(0, 4), ($urandom_range(0, 1) == 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
